pipe_ctrl: RTL
==============

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameters: WIDTH, default 64, PC/target width; REG_AW, default 5, register-index width; RESET_PC, default 0, PC value loaded on reset.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset; ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active high
- mem_stall  in  1  data memory busy; freezes the pipeline
- id_rs1, id_rs2  in  REG_AW  source indices of the instruction in ID
- id_rs1_used, id_rs2_used  in  1  source actually read
- id_rd  in  REG_AW  destination index in ID
- id_reg_write, id_mem_read  in  1  ID instruction writes rd / is a load
- ex_branch_taken  in  1  EX resolved taken branch or jump
- ex_target  in  WIDTH  redirect address
- pc  out  WIDTH  fetch address
- if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1  pipeline register load enables
- if_id_flush, id_ex_bubble  out  1  insert NOP into IF/ID or ID/EX
- fwd_a, fwd_b  out  2  ALU operand source: 00 regfile, 10 EX/MEM, 01 MEM/WB
- stall_cnt, flush_cnt  out  32  performance counters (REQ-018)

Function
REQ-003 The block SHALL keep a shadow control pipeline (valid, rd, reg_write, mem_read) for EX, MEM and WB, advanced under the same enables and bubbles it drives.
REQ-004 Forwarding SHALL be combinational: fwd_a = 10 if EX/MEM entry is valid, has reg_write set, rd != 0 and rd == rs1 of the current EX instruction; else 01 on the same test against MEM/WB; else 00. fwd_b is computed the same way for rs2.
REQ-005 EX/MEM SHALL take priority over MEM/WB when both match; rd == 0 SHALL never forward.
REQ-006 A load-use hazard exists when the EX entry is a valid load with rd != 0 and rd equals id_rs1 (id_rs1_used) or id_rs2 (id_rs2_used).
REQ-007 On a load-use hazard: pc holds; if_id_en=0; id_ex_bubble=1; ex_mem_en=mem_wb_en=1. This lasts exactly one cycle, after which fwd selects 01.
REQ-008 On ex_branch_taken: pc <= ex_target; if_id_flush=1; id_ex_bubble=1; all enables 1. The penalty is 2 bubbles.
REQ-009 Otherwise pc <= pc + 4 and all enables are 1, with no flush or bubble.
REQ-010 Priority SHALL be: mem_stall > ex_branch_taken > load-use > normal.
REQ-011 When mem_stall=1: all enables 0, flush/bubble 0, pc and shadow state held. A branch pending in EX is taken on the first cycle mem_stall=0.
REQ-012 A branch and a load-use hazard in the same cycle SHALL resolve as a branch only; the stall is discarded.
REQ-013 pc SHALL wrap modulo 2^WIDTH.

Reset
REQ-014 On rst: pc=RESET_PC; all shadow valid bits 0; counters 0.
REQ-015 During rst: enables 0, if_id_flush=1, id_ex_bubble=1, fwd_a=fwd_b=00.
REQ-016 rst SHALL override mem_stall and branches. The first cycle after release fetches RESET_PC.

Configuration
REQ-017 Without PIPE_CTRL_PERF_EN: stall_cnt and flush_cnt are tied to 0 and no counter flops exist.
REQ-018 With PIPE_CTRL_PERF_EN: stall_cnt increments once per load-use stall cycle and once per mem_stall cycle; flush_cnt increments once per taken-branch redirect. Both saturate at 2^32-1.

Structure
REQ-019 A shared package SHALL hold the fwd encodings (FWD_RF, FWD_EXMEM, FWD_MEMWB), the PC increment constant 4, and the shadow-stage struct/typedef.
REQ-020 Forwarding logic SHALL be one sub-module, fwd_unit, instantiated once per operand. Hazard and PC logic SHALL remain in pipe_ctrl.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Reset release with RESET_PC=0x1000 -> pc sequence 0x1000, 0x1004, 0x1008; no flush after cycle 1.
- EX: add x5; ID: reads x5 -> fwd_a=10. Next cycle -> fwd_a=01. x0 as rd -> fwd_a=00.
- EX: lw x7; ID: uses rs2=x7 -> one cycle with pc held, if_id_en=0, id_ex_bubble=1; stall_cnt=1 (PERF_EN); afterwards fwd_b=01.
- ex_branch_taken with ex_target=0x2000 at pc 0x1010 -> next pc 0x2000; if_id_flush=id_ex_bubble=1 for one cycle; flush_cnt +1.
- mem_stall held 3 cycles with a taken branch in EX -> pc and enables frozen for 3 cycles, then redirect to target; stall_cnt +3.
- Load-use and taken branch together -> branch only, no extra stall cycle. rst asserted mid-stall -> pc=RESET_PC and valids cleared next cycle.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipe_ctrl definitions: forwarding encodings, PC step, shadow-stage record and control modes.
package pipe_ctrl_pkg;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  localparam int PC_INC = 4;

  // Register indices are carried at this width in the shadow pipeline; REG_AW must not exceed it.
  localparam int REG_AW_MAX = 8;
  typedef logic [REG_AW_MAX-1:0] ridx_t;

  typedef struct packed {
    logic  valid;
    logic  reg_write;
    logic  mem_read;
    ridx_t rd;
  } stage_t;

  typedef enum logic [1:0] {
    CM_NORMAL,
    CM_LOAD_USE,
    CM_BRANCH,
    CM_MEM_STALL
  } ctrl_mode_t;

endpackage

// File: rtl/pipe_ctrl_fwd_unit.sv
// Operand forwarding select for one ALU source: the younger EX/MEM producer wins over MEM/WB, x0 never forwards.
module fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  ridx_t      rs,
  input  stage_t     exmem,
  input  stage_t     memwb,
  output logic [1:0] fwd
);

  logic unused_bits;
  assign unused_bits = exmem.mem_read ^ memwb.mem_read;

  always_comb begin
    fwd = FWD_RF;
    if (exmem.valid && exmem.reg_write && (exmem.rd != '0) && (exmem.rd == rs)) begin
      fwd = FWD_EXMEM;
    end else if (memwb.valid && memwb.reg_write && (memwb.rd != '0) && (memwb.rd == rs)) begin
      fwd = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/PC controller with forwarding selects.
// Optional performance counters are built only when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
  parameter int               WIDTH    = 64,
  parameter int               REG_AW   = 5,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_stall,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              ex_branch_taken,
  input  logic [WIDTH-1:0]  ex_target,
  output logic [WIDTH-1:0]  pc,
  output logic              if_id_en,
  output logic              id_ex_en,
  output logic              ex_mem_en,
  output logic              mem_wb_en,
  output logic              if_id_flush,
  output logic              id_ex_bubble,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
);
  import pipe_ctrl_pkg::*;

  logic [WIDTH-1:0] pc_q;
  stage_t           ex_q, mem_q, wb_q;
  ridx_t            ex_rs1_q, ex_rs2_q;
  ctrl_mode_t       mode;
  logic             load_use;
  logic [1:0]       fwd_a_raw, fwd_b_raw;

  always_comb begin
    load_use = ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) &&
               ((id_rs1_used && (ex_q.rd == ridx_t'(id_rs1))) ||
                (id_rs2_used && (ex_q.rd == ridx_t'(id_rs2))));
  end

  always_comb begin
    if (mem_stall)            mode = CM_MEM_STALL;
    else if (ex_branch_taken) mode = CM_BRANCH;
    else if (load_use)        mode = CM_LOAD_USE;
    else                      mode = CM_NORMAL;
  end

  // Bubbles clear the EX source indices too, so an empty slot can never select a forward.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      ex_q     <= '0;
      mem_q    <= '0;
      wb_q     <= '0;
      ex_rs1_q <= '0;
      ex_rs2_q <= '0;
    end else if (mode != CM_MEM_STALL) begin
      mem_q <= ex_q;
      wb_q  <= mem_q;
      case (mode)
        CM_BRANCH, CM_LOAD_USE: begin
          if (mode == CM_BRANCH) pc_q <= ex_target;
          ex_q     <= '0;
          ex_rs1_q <= '0;
          ex_rs2_q <= '0;
        end
        default: begin
          pc_q     <= pc_q + WIDTH'(PC_INC);
          ex_q     <= '{valid: 1'b1, reg_write: id_reg_write, mem_read: id_mem_read,
                        rd: ridx_t'(id_rd)};
          ex_rs1_q <= ridx_t'(id_rs1);
          ex_rs2_q <= ridx_t'(id_rs2);
        end
      endcase
    end
  end

  always_comb begin
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    if (rst) begin
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else begin
      case (mode)
        CM_MEM_STALL: begin
          if_id_en  = 1'b0;
          id_ex_en  = 1'b0;
          ex_mem_en = 1'b0;
          mem_wb_en = 1'b0;
        end
        CM_BRANCH: begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end
        CM_LOAD_USE: begin
          if_id_en     = 1'b0;
          id_ex_bubble = 1'b1;
        end
        default: ;
      endcase
    end
  end

  fwd_unit u_fwd_a (.rs(ex_rs1_q), .exmem(mem_q), .memwb(wb_q), .fwd(fwd_a_raw));
  fwd_unit u_fwd_b (.rs(ex_rs2_q), .exmem(mem_q), .memwb(wb_q), .fwd(fwd_b_raw));

  assign fwd_a = rst ? FWD_RF : fwd_a_raw;
  assign fwd_b = rst ? FWD_RF : fwd_b_raw;
  assign pc    = pc_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_q, flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (((mode == CM_MEM_STALL) || (mode == CM_LOAD_USE)) && (stall_q != '1))
        stall_q <= stall_q + 32'd1;
      if ((mode == CM_BRANCH) && (flush_q != '1))
        flush_q <= flush_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
